bird_pipe_engine: RTL and testbench
===================================

BIRD_PIPE_ENGINE -- requirements
Module: bird_pipe_engine

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, meaning horizontal pixel count.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, meaning vertical pixel count.
REQ-003 SHALL have parameter PIPE_GAP, default 100, meaning half-opening of the pipe gap in pixels.
REQ-004 SHALL have parameter BIRD_HEIGHT, default 20, meaning bird sprite height in pixels.
REQ-005 SHALL have parameter TICK_DIV, default 833333, meaning clocks per physics frame.
REQ-006 SHALL have parameters GRAVITY (default 1), FLAP_VEL (default -8), MAX_FALL (default 8) and PIPE_SPEED (default 2), all in pixels per frame.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port flap_button, input, 1 bit: synchronous, level-sensitive player input.
REQ-010 SHALL have port state, input, 2 bits: game state from game_controller (0 IDLE, 1 PLAY, 2 OVER).
REQ-011 SHALL have port collision_in, input, 1 bit: collision flag from game_controller.
REQ-012 SHALL have outputs bird_y, pipe_x, pipe_y_top and pipe_y_bot, each 10 bits, in pixel coordinates.
REQ-013 SHALL have output frame_tick, 1 bit: a one-clock pulse per physics frame.
REQ-014 SHALL have output score, 8 bits: count of pipes passed.

Function
REQ-015 SHALL count 0..TICK_DIV-1 and pulse frame_tick in the clock where the count wraps.
- The counter free-runs in every state.
REQ-016 SHALL detect flap_button rising edges and latch them into flap_pend.
- flap_pend clears on the next frame_tick.
- A rising edge coinciding with the tick applies on the following tick.
REQ-017 SHALL update physics only when frame_tick=1, state=PLAY and collision_in=0.
REQ-018 On a physics update, SHALL set vel = FLAP_VEL if flap_pend, else min(vel+GRAVITY, MAX_FALL).
- vel is signed 8-bit.
REQ-019 On the same update, SHALL set bird_y = clamp(bird_y + new vel, 0, SCREEN_HEIGHT-BIRD_HEIGHT).
- The sum is computed in signed 12-bit.
- Hitting the top clamp sets vel to 0.
REQ-020 On an update with pipe_x >= PIPE_SPEED, SHALL decrement pipe_x by PIPE_SPEED.
REQ-021 On an update with pipe_x < PIPE_SPEED, SHALL do all of the following in the same cycle:
- wrap pipe_x to SCREEN_WIDTH-1;
- load a new gap_center;
- increment score, saturating at 255.
REQ-022 SHALL drive pipe_y_bot = gap_center - PIPE_GAP and pipe_y_top = gap_center + PIPE_GAP, both combinational.
REQ-023 In IDLE, SHALL hold the start values every clock:
- bird_y = SCREEN_HEIGHT/2, vel = 0;
- pipe_x = SCREEN_WIDTH-1, gap_center = 190, score = 0.
REQ-024 In OVER, or whenever collision_in=1, SHALL freeze bird_y, pipe_x, gap_center and score, and SHALL clear flap_pend.
REQ-025 For state code 3, SHALL behave as for OVER.

Reset
REQ-026 Asserting reset SHALL immediately force:
- the IDLE start values (REQ-023);
- tick counter 0, frame_tick 0, flap_pend 0, edge register 0;
- the LFSR to its seed 8'hA5.
REQ-027 Reset asserted mid-frame or mid-PLAY SHALL discard all pending flaps and partial tick counts.

Configuration
REQ-028 With PIPE_RANDOM_EN defined, each wrap SHALL:
- load gap_center = PIPE_GAP + lfsr;
- then step the 8-bit LFSR (taps 8,6,5,4).
REQ-029 Without PIPE_RANDOM_EN, SHALL exclude the LFSR from the build and SHALL reload gap_center with constant 190 on every wrap.

Structure
REQ-030 A shared package game_pkg SHALL hold:
- the state enum (IDLE, PLAY, OVER);
- the GAP_Y_DEFAULT=190 and LFSR_SEED constants;
- the 10-bit coordinate typedef.
REQ-031 The LFSR SHALL be a sub-module named gap_lfsr.
- Ports: clk, reset, step, value[7:0].

Verification (TICK_DIV=4)
REQ-032 Scenario: reset, then state=IDLE for 20 clocks -> bird_y=240, pipe_x=639, pipe_y_bot=90, pipe_y_top=290, score=0.
REQ-033 Scenario: state=PLAY, no flap, 3 ticks -> bird_y=240→241→243→246 and pipe_x 639→637→635→633.
REQ-034 Scenario: in PLAY, pulse flap_button 1 clock mid-frame -> the next tick gives vel=-8 and bird_y decreases by 8; flap_pend clears.
REQ-035 Scenario: in PLAY, hold until pipe_x=1 -> the next tick gives pipe_x=639 and score=1.
- Without PIPE_RANDOM_EN: pipe_y_bot=90.
- With PIPE_RANDOM_EN: gap_center=100+8'hA5=265.
REQ-036 Scenario: raise collision_in during PLAY for 10 ticks -> all outputs frozen; frame_tick still pulses.
REQ-037 Scenario: assert reset mid-fall with bird_y=400 -> bird_y=240 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types and constants: state encoding, pixel coordinate type,
// default pipe gap centre, LFSR seed and its step function.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef logic [9:0] coord_t;

  localparam coord_t     GAP_Y_DEFAULT = 10'd190;
  localparam logic [7:0] LFSR_SEED     = 8'hA5;

  // Fibonacci LFSR x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/gap_lfsr.sv
// 8-bit LFSR that randomises the pipe gap centre. Only compiled when
// PIPE_RANDOM_EN is defined; the default build contains no LFSR.
`ifdef PIPE_RANDOM_EN
module gap_lfsr
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule
`endif

// File: rtl/bird_pipe_engine.sv
// Bird physics, scrolling pipe and score for a flappy-bird style game.
// Define PIPE_RANDOM_EN to randomise the gap centre on each pipe wrap.
module bird_pipe_engine
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_GAP      = 100,
  parameter int BIRD_HEIGHT   = 20,
  parameter int TICK_DIV      = 833333,
  parameter int GRAVITY       = 1,
  parameter int FLAP_VEL      = -8,
  parameter int MAX_FALL      = 8,
  parameter int PIPE_SPEED    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flap_button,
  input  logic [1:0] state,
  input  logic       collision_in,
  output logic [9:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic       frame_tick,
  output logic [7:0] score
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam coord_t                Y_START  = coord_t'(SCREEN_HEIGHT / 2);
  localparam coord_t                X_START  = coord_t'(SCREEN_WIDTH - 1);
  localparam coord_t                X_STEP   = coord_t'(PIPE_SPEED);
  localparam logic signed [11:0]    Y_MAX_S  = 12'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [7:0]     FLAP_V8  = 8'(FLAP_VEL);
  localparam logic signed [8:0]     GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]     MAXF9    = 9'(MAX_FALL);

  game_state_t st;
  assign st = game_state_t'(state);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              frame_tick_q, frame_tick_d;
  logic              flap_prev_q, flap_prev_d;
  logic              flap_pend_q, flap_pend_d;
  logic signed [7:0] vel_q, vel_d;
  coord_t            bird_y_q, bird_y_d;
  coord_t            pipe_x_q, pipe_x_d;
  coord_t            gap_q, gap_d;
  logic [7:0]        score_q, score_d;

  logic               cnt_wrap;
  logic               flap_rise;
  logic               pend_next;
  logic               phys_en;
  logic               pipe_wrap;
  logic signed [8:0]  vel_sum;
  logic signed [7:0]  vel_new;
  logic signed [11:0] y_sum;
  coord_t             gap_new;

  assign phys_en   = frame_tick_q & (st == PLAY) & ~collision_in;
  assign pipe_wrap = (pipe_x_q < X_STEP);

`ifdef PIPE_RANDOM_EN
  logic [7:0] lfsr_val;

  gap_lfsr u_gap_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (phys_en & pipe_wrap),
    .value (lfsr_val)
  );

  assign gap_new = coord_t'(PIPE_GAP) + {2'b00, lfsr_val};
`else
  assign gap_new = GAP_Y_DEFAULT;
`endif

  always_comb begin
    cnt_wrap     = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d        = cnt_wrap ? '0 : cnt_q + CW'(1);
    frame_tick_d = cnt_wrap;

    flap_rise   = flap_button & ~flap_prev_q;
    flap_prev_d = flap_button;
    // An edge arriving on the tick itself is kept for the following tick
    pend_next   = frame_tick_q ? flap_rise : (flap_pend_q | flap_rise);

    vel_sum = {vel_q[7], vel_q} + GRAV9;
    if (flap_pend_q)          vel_new = FLAP_V8;
    else if (vel_sum > MAXF9) vel_new = MAXF9[7:0];
    else                      vel_new = vel_sum[7:0];
    y_sum = {2'b00, bird_y_q} + {{4{vel_new[7]}}, vel_new};

    flap_pend_d = flap_pend_q;
    vel_d       = vel_q;
    bird_y_d    = bird_y_q;
    pipe_x_d    = pipe_x_q;
    gap_d       = gap_q;
    score_d     = score_q;

    case (st)
      IDLE: begin
        flap_pend_d = pend_next;
        vel_d       = '0;
        bird_y_d    = Y_START;
        pipe_x_d    = X_START;
        gap_d       = GAP_Y_DEFAULT;
        score_d     = '0;
      end
      PLAY: begin
        if (collision_in) begin
          flap_pend_d = 1'b0;
        end else begin
          flap_pend_d = pend_next;
          if (frame_tick_q) begin
            if (y_sum < 12'sd0) begin
              bird_y_d = '0;
              vel_d    = '0;
            end else if (y_sum > Y_MAX_S) begin
              bird_y_d = coord_t'(Y_MAX_S);
              vel_d    = vel_new;
            end else begin
              bird_y_d = y_sum[9:0];
              vel_d    = vel_new;
            end
            if (pipe_wrap) begin
              pipe_x_d = X_START;
              gap_d    = gap_new;
              if (score_q != '1) score_d = score_q + 8'd1;
            end else begin
              pipe_x_d = pipe_x_q - X_STEP;
            end
          end
        end
      end
      default: flap_pend_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      flap_prev_q  <= 1'b0;
      flap_pend_q  <= 1'b0;
      vel_q        <= '0;
      bird_y_q     <= Y_START;
      pipe_x_q     <= X_START;
      gap_q        <= GAP_Y_DEFAULT;
      score_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      flap_prev_q  <= flap_prev_d;
      flap_pend_q  <= flap_pend_d;
      vel_q        <= vel_d;
      bird_y_q     <= bird_y_d;
      pipe_x_q     <= pipe_x_d;
      gap_q        <= gap_d;
      score_q      <= score_d;
    end
  end

  assign bird_y     = bird_y_q;
  assign pipe_x     = pipe_x_q;
  assign pipe_y_bot = gap_q - coord_t'(PIPE_GAP);
  assign pipe_y_top = gap_q + coord_t'(PIPE_GAP);
  assign frame_tick = frame_tick_q;
  assign score      = score_q;

endmodule

// File: tb/tb_bird_pipe_engine.sv
// Bench for bird_pipe_engine with TICK_DIV=4: directed table, corner-case
// sequences and randomized play checked against a behavioural game model.
module tb_bird_pipe_engine;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       flap_button;
  logic [1:0] state;
  logic       collision_in;
  logic [9:0] bird_y, pipe_x, pipe_y_top, pipe_y_bot;
  logic       frame_tick;
  logic [7:0] score;

  bird_pipe_engine #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .reset        (reset),
    .flap_button  (flap_button),
    .state        (state),
    .collision_in (collision_in),
    .bird_y       (bird_y),
    .pipe_x       (pipe_x),
    .pipe_y_top   (pipe_y_top),
    .pipe_y_bot   (pipe_y_bot),
    .frame_tick   (frame_tick),
    .score        (score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: whole-number positions, edges counted since reset release
  int m_n, m_tick, m_prev, m_pend, m_vel, m_y, m_x, m_gap, m_score, m_lfsr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_tick = 0; m_prev = 0; m_pend = 0; m_vel = 0;
    m_y = 240; m_x = 639; m_gap = 190; m_score = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step(input int f, input int s, input int c);
    int old_tick, rise, nv, ny;
    old_tick = m_tick;
    rise = (f != 0 && m_prev == 0) ? 1 : 0;
    m_n++;
    m_tick = (m_n % TD == 0) ? 1 : 0;
    if (s == 0) begin
      m_y = 240; m_vel = 0; m_x = 639; m_gap = 190; m_score = 0;
      m_pend = old_tick ? rise : (m_pend | rise);
    end else if (s == 1 && c == 0) begin
      if (old_tick != 0) begin
        nv = m_pend ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        ny = m_y + nv;
        if (ny < 0) begin ny = 0; nv = 0; end
        else if (ny > 460) ny = 460;
        m_vel = nv; m_y = ny;
        if (m_x >= 2) m_x = m_x - 2;
        else begin
          m_x = 639;
`ifdef PIPE_RANDOM_EN
          m_gap = 100 + m_lfsr;
          m_lfsr = ((m_lfsr << 1) & 8'hFF) | ($countones(m_lfsr & 8'hB8) & 1);
`else
          m_gap = 190;
`endif
          if (m_score < 255) m_score++;
        end
      end
      m_pend = old_tick ? rise : (m_pend | rise);
    end else begin
      m_pend = 0;
    end
    m_prev = f;
  endtask

  task automatic check_all();
    chk("bird_y", int'(bird_y), m_y);
    chk("pipe_x", int'(pipe_x), m_x);
    chk("pipe_y_top", int'(pipe_y_top), m_gap + 100);
    chk("pipe_y_bot", int'(pipe_y_bot), m_gap - 100);
    chk("frame_tick", int'(frame_tick), m_tick);
    chk("score", int'(score), m_score);
  endtask

  task automatic step(input bit f, input bit [1:0] s, input bit c);
    flap_button = f; state = s; collision_in = c;
    @(posedge clk);
    model_step(int'(f), int'(s), int'(c));
    #1;
    check_all();
  endtask

  typedef struct {
    bit       flap;
    bit [1:0] st;
    bit       coll;
    int       clocks;
    int       y, x, sc, bot;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ticks, guard;
    tbl[0] = '{0, 2'd0, 0, 20, 240, 639, 0, 90};
    tbl[1] = '{0, 2'd1, 0, 1,  241, 637, 0, 90};
    tbl[2] = '{0, 2'd1, 0, 4,  243, 635, 0, 90};
    tbl[3] = '{0, 2'd1, 0, 4,  246, 633, 0, 90};
    tbl[4] = '{1, 2'd1, 0, 1,  246, 633, 0, 90};
    tbl[5] = '{0, 2'd1, 0, 4,  238, 631, 0, 90};
    tbl[6] = '{0, 2'd1, 0, 4,  231, 629, 0, 90};

    reset = 1'b1; flap_button = 1'b0; state = 2'd0; collision_in = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_bird_y", int'(bird_y), 240);
    chk("rst_pipe_x", int'(pipe_x), 639);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_score", int'(score), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].clocks; k++) step(tbl[i].flap, tbl[i].st, tbl[i].coll);
      chk($sformatf("tbl%0d_y", i), int'(bird_y), tbl[i].y);
      chk($sformatf("tbl%0d_x", i), int'(pipe_x), tbl[i].x);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
      chk($sformatf("tbl%0d_bot", i), int'(pipe_y_bot), tbl[i].bot);
    end

    // Collision freeze: ten frames elapse but nothing moves
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 2'd1, 1'b1);
      if (frame_tick) ticks++;
    end
    chk("coll_ticks", ticks, 10);
    chk("coll_y", int'(bird_y), 231);
    chk("coll_x", int'(pipe_x), 629);

    // Pipe wrap
    guard = 0;
    while (pipe_x != 10'd1 && guard < 2000) begin step(1'b0, 2'd1, 1'b0); guard++; end
    chk("wrap_reach_x1", int'(pipe_x), 1);
    guard = 0;
    while (pipe_x == 10'd1 && guard < 8) begin step(1'b0, 2'd1, 1'b0); guard++; end
    chk("wrap_x", int'(pipe_x), 639);
    chk("wrap_score", int'(score), 1);
`ifdef PIPE_RANDOM_EN
    chk("wrap_bot", int'(pipe_y_bot), 165);
`else
    chk("wrap_bot", int'(pipe_y_bot), 90);
`endif

    // Randomized play with occasional state changes, collisions and flaps
    for (int blk = 0; blk < 60; blk++) begin
      int r;
      bit [1:0] s;
      r = $urandom_range(0, 99);
      s = (r < 80) ? 2'd1 : (r < 88) ? 2'd0 : (r < 95) ? 2'd2 : 2'd3;
      for (int k = 0; k < 50; k++)
        step(($urandom_range(0, 99) < 30), s, ($urandom_range(0, 99) < 4));
    end

    // Asynchronous reset mid-fall
    guard = 0;
    while (bird_y < 10'd400 && guard < 500) begin step(1'b0, 2'd1, 1'b0); guard++; end
    chk("fall_reach_400", int'(bird_y >= 10'd400), 1);
    flap_button = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_bird_y", int'(bird_y), 240);
    chk("async_pipe_x", int'(pipe_x), 639);
    chk("async_tick", int'(frame_tick), 0);
    chk("async_score", int'(score), 0);
    chk("async_top", int'(pipe_y_top), 290);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) step(1'b0, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
